clk_enable_gen: RTL and testbench
=================================

// Module: clk_enable_gen
// PURPOSE
//  Parametrised, reconfigurable clock-enable generator. Produces NUM_CH single-cycle enable strobes
//  from refclk at runtime-programmable integer divide ratios. A settle/lock FSM gates the strobes.
//  Sits between the board PLL output and the CPU/peripheral domains, replacing fixed extra PLL
//  outputs with phase-aligned enables on a single clock.
// PARAMETERS
//  NUM_CH       3                         number of enable channels (>=1)
//  DIV_W        16                        width of each divide ratio
//  DIV_INIT     {16'd1,16'd2,16'd5}       packed reset divide ratios, ch0 in LSBs (ch0 /5, ch1 /2, ch2 /1)
//  LOCK_CYCLES  1024                      settle cycles before locked asserts (>=1)
// PORTS
//  refclk     in   1                      sole clock, rising edge
//  rst        in   1                      async active-high reset
//  cfg_valid  in   1                      reconfiguration request
//  cfg_ready  out  1                      high only in LOCKED; transfer = cfg_valid & cfg_ready
//  cfg_ch     in   $clog2(NUM_CH) (min 1)  channel to reprogram
//  cfg_div    in   DIV_W                  new divide ratio
//  outen      out  NUM_CH                 per-channel enable strobes (registered)
//  locked     out  1                      all strobes valid and phase-aligned (registered)
//  outclk     out  NUM_CH                 only with CLKGEN_OUTCLK_EN
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation):
//   - state=RESET; div_i=DIV_INIT; cnt_i=0; lock_cnt=0; outen=0; locked=0; cfg_ready=0; outclk=0.
//  FSM:
//   - RESET -> SETTLE on first refclk edge with rst low.
//   - SETTLE: lock_cnt increments each cycle; lock_cnt==LOCK_CYCLES-1 -> LOCKED.
//   - LOCKED: locked=1 and cfg_ready=1, both registered, high from the cycle the state is LOCKED.
//   - LOCKED + transfer with cfg_ch<NUM_CH -> SETTLE. Next edge: div[cfg_ch] loaded, all cnt_i=0,
//     lock_cnt=0, locked=0, cfg_ready=0, outen=0.
//   - LOCKED + transfer with cfg_ch>=NUM_CH: handshake completes, no state or divider change.
//   - locked first rises LOCK_CYCLES+1 edges after rst deasserts.
//  Channel counters:
//   - cnt_i held at 0 outside LOCKED. In LOCKED, cnt_i increments and wraps from div_i-1 to 0.
//   - outen_i <= (state==LOCKED) & (cnt_i==div_i-1). One-cycle pulse every div_i cycles.
//   - First pulse occurs div_i cycles after locked rises; all channels share cnt=0 at lock,
//     so strobes are phase-aligned (coincide every lcm of the ratios).
//   - div_i==1: outen_i continuously high while locked.
//   - cfg_div==0 is stored as 1 (saturate). Same rule applies to any DIV_INIT field of 0.
//   - cnt_i is DIV_W bits wide; no overflow, since cnt_i < div_i <= 2^DIV_W-1.
//  Handshake:
//   - cfg_valid may be held while cfg_ready=0; its payload must stay stable.
//   - At most one transfer per lock cycle. The transfer drops cfg_ready on the next edge.
//  Simultaneous events:
//   - rst overrides everything.
//   - A transfer on the cycle LOCKED is entered is impossible, because cfg_ready is registered.
// CONFIGURATION
//  CLKGEN_OUTCLK_EN defined:
//   - outclk port and logic present.
//   - outclk_i <= (state==LOCKED) & (cnt_i < ceil(div_i/2)).
//   - outclk_i is high ceil(div/2) cycles and low floor(div/2) cycles; 50% duty for even div.
//   - div=1: outclk_i constant 1 while locked. Held 0 when not locked.
//  CLKGEN_OUTCLK_EN undefined:
//   - outclk port absent, no related flops. All other behaviour identical.
// TESTING
//  1. LOCK_CYCLES=8, default DIV_INIT, release rst at edge 0 -> locked=1 after edge 9;
//     outen[0] pulses every 5, outen[1] every 2, outen[2] constant 1.
//  2. Locked; transfer cfg_ch=1, cfg_div=3 -> next edge locked=0, outen=0, cfg_ready=0;
//     relock after 8 more edges; outen[1] period 3, first pulse 3 cycles after locked.
//  3. Transfer cfg_div=0 on ch0 -> after relock outen[0] constant 1.
//  4. Transfer cfg_ch=3 (NUM_CH=3) -> cfg_ready stays 1, locked stays 1, pulse pattern unchanged.
//  5. Assert rst mid-pulse train -> outen, locked, cfg_ready go 0 immediately;
//     dividers return to DIV_INIT after relock.
//  6. CLKGEN_OUTCLK_EN, div=5 -> outclk_0 pattern 1,1,1,0,0 repeating; div=2 -> 1,0 repeating.

Source files
------------

// File: rtl/clk_enable_gen.sv
// clk_enable_gen -- runtime-reconfigurable clock-enable generator.
//
// Produces NUM_CH single-cycle enable strobes on refclk at programmable
// integer divide ratios. A settle/lock FSM holds every strobe low for
// LOCK_CYCLES cycles after reset or after a reconfiguration, then releases
// all channel counters from zero together so the strobes stay phase-aligned.
//
// Optional feature macro: CLKGEN_OUTCLK_EN adds the outclk port, a
// ceil(div/2)-high / floor(div/2)-low divided clock per channel.
//
// Ports:
//   refclk     in   sole clock, rising edge
//   rst        in   async active-high reset
//   cfg_valid  in   reconfiguration request
//   cfg_ready  out  high only while locked; transfer = cfg_valid & cfg_ready
//   cfg_ch     in   channel to reprogram (out-of-range: handshake only)
//   cfg_div    in   new divide ratio (0 is stored as 1)
//   outen      out  per-channel enable strobes (registered)
//   locked     out  strobes valid and phase-aligned (registered)
//   outclk     out  per-channel divided clock (CLKGEN_OUTCLK_EN only)

// Per-channel divider: ratio register, wrap counter, strobe flop.
module clk_enable_ch #(
  parameter int               DIV_W   = 16,
  parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(1)
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             i_run,   // locked and not being reconfigured
  input  logic             i_load,  // load i_div into this channel
  input  logic [DIV_W-1:0] i_div,
  output logic             o_outen
`ifdef CLKGEN_OUTCLK_EN
  ,
  output logic             o_outclk
`endif
);
  // A zero ratio is meaningless; treat it as divide-by-1.
  localparam logic [DIV_W-1:0] DIV_SAT = (DIV_RST == '0) ? DIV_W'(1) : DIV_RST;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             r_outen;
  logic             w_last;

  assign w_last = (r_cnt == (r_div - DIV_W'(1)));

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_div   <= DIV_SAT;
      r_cnt   <= '0;
      r_outen <= 1'b0;
    end else begin
      if (i_load) r_div <= (i_div == '0) ? DIV_W'(1) : i_div;
      // Counters sit at zero until lock so every channel starts in phase.
      if (!i_run)      r_cnt <= '0;
      else if (w_last) r_cnt <= '0;
      else             r_cnt <= r_cnt + DIV_W'(1);
      r_outen <= i_run & w_last;
    end
  end

  assign o_outen = r_outen;

`ifdef CLKGEN_OUTCLK_EN
  // ceil(div/2) computed one bit wider so div = 2^DIV_W-1 cannot overflow.
  logic [DIV_W:0] w_half;
  logic           r_outclk;

  assign w_half = ({1'b0, r_div} + (DIV_W+1)'(1)) >> 1;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) r_outclk <= 1'b0;
    else     r_outclk <= i_run & ({1'b0, r_cnt} < w_half);
  end

  assign o_outclk = r_outclk;
`endif
endmodule

module clk_enable_gen #(
  parameter int                          NUM_CH      = 3,
  parameter int                          DIV_W       = 16,
  parameter logic [NUM_CH*DIV_W-1:0]     DIV_INIT    = {16'd1, 16'd2, 16'd5},
  parameter int                          LOCK_CYCLES = 1024,
  localparam int                         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] outen,
  output logic              locked
`ifdef CLKGEN_OUTCLK_EN
  ,
  output logic [NUM_CH-1:0] outclk
`endif
);
  localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {ST_RESET, ST_SETTLE, ST_LOCKED} state_t;

  state_t            r_state, w_state_nxt;
  logic [LC_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;
  logic              r_locked;
  logic              r_cfg_ready;
  logic              w_xfer;
  logic              w_ch_ok;
  logic              w_reconfig;
  logic              w_run;
  logic [NUM_CH-1:0] w_load;

  assign w_xfer     = cfg_valid & r_cfg_ready;
  assign w_ch_ok    = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));
  // Out-of-range channel completes the handshake but changes nothing.
  assign w_reconfig = (r_state == ST_LOCKED) & w_xfer & w_ch_ok;
  assign w_run      = (r_state == ST_LOCKED) & ~w_reconfig;

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = '0;
    case (r_state)
      ST_RESET:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (r_lock_cnt == LC_W'(LOCK_CYCLES - 1)) w_state_nxt = ST_LOCKED;
        else w_lock_cnt_nxt = r_lock_cnt + LC_W'(1);
      end
      ST_LOCKED: if (w_reconfig) w_state_nxt = ST_SETTLE;
      default:   w_state_nxt = ST_RESET;
    endcase
  end

  // locked/cfg_ready track the next state so they are high exactly while
  // the registered state is LOCKED.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RESET;
      r_lock_cnt  <= '0;
      r_locked    <= 1'b0;
      r_cfg_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_cfg_ready <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign locked    = r_locked;
  assign cfg_ready = r_cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_load[i] = w_reconfig & (cfg_ch == CH_W'(i));

    clk_enable_ch #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_INIT[i*DIV_W +: DIV_W])
    ) u_ch (
      .refclk  (refclk),
      .rst     (rst),
      .i_run   (w_run),
      .i_load  (w_load[i]),
      .i_div   (cfg_div),
      .o_outen (outen[i])
`ifdef CLKGEN_OUTCLK_EN
      ,
      .o_outclk(outclk[i])
`endif
    );
  end
endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen (NUM_CH=3, DIV_INIT 5/2/1, LOCK_CYCLES=8).
// A per-edge vector table covers lock-up, reconfiguration of ch1 to /3,
// ch0 to /0 (saturates to /1) and an out-of-range channel request; hand
// sequences cover asynchronous reset mid-stream and, when built with
// CLKGEN_OUTCLK_EN, the outclk duty pattern.
module tb_clk_enable_gen;
  logic        refclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_div = '0;
  logic        cfg_ready;
  logic        locked;
  logic [2:0]  outen;
`ifdef CLKGEN_OUTCLK_EN
  logic [2:0]  outclk;
`endif

  clk_enable_gen #(.LOCK_CYCLES(8)) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .outen    (outen),
    .locked   (locked)
`ifdef CLKGEN_OUTCLK_EN
    ,
    .outclk   (outclk)
`endif
  );

  always #5 refclk = ~refclk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        cv;
    logic [1:0]  ch;
    logic [15:0] div;
    logic [2:0]  outen;
    logic        lk;
    logic        rdy;
  } vec_t;

  vec_t tbl [1:50];

  function automatic vec_t mk(input logic cv, input logic [1:0] ch, input logic [15:0] dv,
                              input logic [2:0] oe, input logic lk, input logic rdy);
    vec_t v;
    v.cv = cv; v.ch = ch; v.div = dv; v.outen = oe; v.lk = lk; v.rdy = rdy;
    return v;
  endfunction

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Expected values for edges 8..15 after a reset release (divs 5/2/1).
  logic [2:0] rs_outen  [8:15];
  logic       rs_lk     [8:15];
  logic [2:0] rs_outclk [8:15];

  initial begin
    // Row i = inputs driven before edge i, outputs expected after edge i.
    for (int i = 1; i <= 8; i++) tbl[i] = mk(0, 0, 0, 3'b000, 0, 0);
    tbl[9]  = mk(0, 0, 0, 3'b000, 1, 1);
    tbl[10] = mk(0, 0, 0, 3'b100, 1, 1);
    tbl[11] = mk(0, 0, 0, 3'b110, 1, 1);
    tbl[12] = mk(0, 0, 0, 3'b100, 1, 1);
    tbl[13] = mk(0, 0, 0, 3'b110, 1, 1);
    tbl[14] = mk(0, 0, 0, 3'b101, 1, 1);
    tbl[15] = mk(0, 0, 0, 3'b110, 1, 1);
    tbl[16] = mk(0, 0, 0, 3'b100, 1, 1);
    tbl[17] = mk(0, 0, 0, 3'b110, 1, 1);
    tbl[18] = mk(0, 0, 0, 3'b100, 1, 1);
    tbl[19] = mk(0, 0, 0, 3'b111, 1, 1);
    // ch1 -> /3
    tbl[20] = mk(1, 1, 3, 3'b000, 0, 0);
    for (int i = 21; i <= 27; i++) tbl[i] = mk(0, 0, 0, 3'b000, 0, 0);
    tbl[28] = mk(0, 0, 0, 3'b000, 1, 1);
    tbl[29] = mk(0, 0, 0, 3'b100, 1, 1);
    tbl[30] = mk(0, 0, 0, 3'b100, 1, 1);
    tbl[31] = mk(0, 0, 0, 3'b110, 1, 1);
    tbl[32] = mk(0, 0, 0, 3'b100, 1, 1);
    tbl[33] = mk(0, 0, 0, 3'b101, 1, 1);
    tbl[34] = mk(0, 0, 0, 3'b110, 1, 1);
    // ch0 -> /0, saturates to /1
    tbl[35] = mk(1, 0, 0, 3'b000, 0, 0);
    for (int i = 36; i <= 42; i++) tbl[i] = mk(0, 0, 0, 3'b000, 0, 0);
    tbl[43] = mk(0, 0, 0, 3'b000, 1, 1);
    tbl[44] = mk(0, 0, 0, 3'b101, 1, 1);
    tbl[45] = mk(0, 0, 0, 3'b101, 1, 1);
    tbl[46] = mk(0, 0, 0, 3'b111, 1, 1);
    tbl[47] = mk(0, 0, 0, 3'b101, 1, 1);
    // out-of-range channel: handshake only
    tbl[48] = mk(1, 3, 7, 3'b101, 1, 1);
    tbl[49] = mk(0, 0, 0, 3'b111, 1, 1);
    tbl[50] = mk(0, 0, 0, 3'b101, 1, 1);

    rs_outen  = '{3'b000, 3'b000, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b110};
    rs_lk     = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rs_outclk = '{3'b000, 3'b000, 3'b111, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101};

    // Reset state, held over two edges.
    tick();
    tick();
    chk("reset_state", {3'b0, outen, locked, cfg_ready}, 8'b0);
`ifdef CLKGEN_OUTCLK_EN
    chk("reset_outclk", {5'b0, outclk}, 8'b0);
`endif
    rst = 1'b0;  // edge just passed is edge 0

    for (int i = 1; i <= 50; i++) begin
      cfg_valid = tbl[i].cv;
      cfg_ch    = tbl[i].ch;
      cfg_div   = tbl[i].div;
      tick();
      chk($sformatf("vec_edge%0d", i), {3'b0, outen, locked, cfg_ready},
          {3'b0, tbl[i].outen, tbl[i].lk, tbl[i].rdy});
    end
    cfg_valid = 1'b0;

    // Async reset mid pulse train: outputs drop without a clock edge.
    rst = 1'b1;
    #1;
    chk("async_rst_immediate", {3'b0, outen, locked, cfg_ready}, 8'b0);
    tick();
    chk("rst_held", {3'b0, outen, locked, cfg_ready}, 8'b0);
    rst = 1'b0;

    // Relock with DIV_INIT restored (ch0 /5, ch1 /2 again).
    for (int e = 1; e <= 15; e++) begin
      tick();
      if (e >= 8) begin
        chk($sformatf("relock_edge%0d", e), {3'b0, outen, locked, cfg_ready},
            {3'b0, rs_outen[e], rs_lk[e], rs_lk[e]});
`ifdef CLKGEN_OUTCLK_EN
        chk($sformatf("outclk_edge%0d", e), {5'b0, outclk}, {5'b0, rs_outclk[e]});
`endif
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
